// File: rtl/pll_drp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_drp_sequencer
// Brief    : Power-on reset and masked read-modify-write DRP reconfiguration
//            sequencer for a 7-series PLL, with a qualified LOCKED output.
// Revision : 1.0 - initial release
// ============================================================================
module pll_drp_sequencer #(
  parameter int RST_CYCLES   = 8,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        refclk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [15:0] cmd_mask,
  input  logic        cmd_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        locked_o,
  output logic        pll_rst,
  input  logic        pll_locked,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy
);

  localparam int               CNT_W       = 16;
  localparam logic [CNT_W-1:0] C_RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
  localparam logic [1:0]       C_ERR_NONE  = 2'd0;
  localparam logic [1:0]       C_ERR_DRDY  = 2'd1;
  localparam logic [1:0]       C_ERR_LOCK  = 2'd2;

  typedef enum logic [3:0] {
    ST_INIT      = 4'd0,
    ST_IDLE      = 4'd1,
    ST_RD        = 4'd2,
    ST_WAIT_RD   = 4'd3,
    ST_WR        = 4'd4,
    ST_WAIT_WR   = 4'd5,
    ST_ACCEPT    = 4'd6,
    ST_RELEASE   = 4'd7,
    ST_WAIT_LOCK = 4'd8
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lock_meta;
  logic             r_lock_s;
  logic [6:0]       r_addr;
  logic [15:0]      r_data;
  logic [15:0]      r_mask;
  logic             r_last;
  logic             r_por;
  logic             r_abort;
  logic [15:0]      r_di;
  logic             r_pll_rst;
  logic             r_den;
  logic             r_dwe;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;

  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_drdy_to;
  logic             w_lock_to;
  logic             w_lock_ok;
  logic             w_pll_rst_next;
  logic [15:0]      w_new;

  assign w_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_ACCEPT);
  assign w_accept    = cmd_valid & w_cmd_ready;
  // Mask bit 1 keeps the value read from the PLL, 0 takes the command bit.
  assign w_new       = (drp_do & r_mask) | (r_data & ~r_mask);

  always_comb begin
    w_state_next = r_state;
    w_drdy_to    = 1'b0;
    w_lock_to    = 1'b0;
    w_lock_ok    = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == C_RST_LAST) w_state_next = ST_WAIT_LOCK;
      end
      ST_IDLE: begin
        if (cmd_valid) w_state_next = ST_RD;
      end
      ST_RD: begin
        w_state_next = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (drp_drdy) begin
          w_state_next = ST_WR;
        end else if (r_cnt == C_DRDY_LAST) begin
          w_drdy_to    = 1'b1;
          w_state_next = ST_WAIT_LOCK;
        end
      end
      ST_WR: begin
        w_state_next = ST_WAIT_WR;
      end
      ST_WAIT_WR: begin
        if (drp_drdy) begin
          w_state_next = r_last ? ST_RELEASE : ST_ACCEPT;
        end else if (r_cnt == C_DRDY_LAST) begin
          w_drdy_to    = 1'b1;
          w_state_next = ST_WAIT_LOCK;
        end
      end
      ST_ACCEPT: begin
        if (cmd_valid) w_state_next = ST_RD;
      end
      ST_RELEASE: begin
        w_state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_lock_ok    = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_cnt == C_LOCK_LAST) begin
          w_lock_to    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  // The PLL is only out of reset while waiting for lock or running in IDLE.
  always_comb begin
    w_pll_rst_next = 1'b1;
    case (w_state_next)
      ST_IDLE, ST_RELEASE, ST_WAIT_LOCK: w_pll_rst_next = 1'b0;
      default:                           w_pll_rst_next = 1'b1;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_mask      <= '0;
      r_last      <= 1'b0;
      r_por       <= 1'b1;
      r_abort     <= 1'b0;
      r_di        <= '0;
      r_pll_rst   <= 1'b1;
      r_den       <= 1'b0;
      r_dwe       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= C_ERR_NONE;
    end else begin
      r_state     <= w_state_next;
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;

      // One counter serves every timed state; it restarts on each state change.
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != C_CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      r_pll_rst <= w_pll_rst_next;
      r_den     <= (w_state_next == ST_RD) || (w_state_next == ST_WR);
      r_dwe     <= (w_state_next == ST_WR);
      r_done    <= w_lock_ok & ~r_por & ~r_abort;
      r_err     <= w_drdy_to | w_lock_to;

      if (w_accept) begin
        r_addr     <= cmd_addr;
        r_data     <= cmd_data;
        r_mask     <= cmd_mask;
        r_last     <= cmd_last;
        r_por      <= 1'b0;
        r_abort    <= 1'b0;
        r_err_code <= C_ERR_NONE;
      end

      if ((r_state == ST_WAIT_RD) && drp_drdy) begin
        r_di <= w_new;
      end

      if (w_drdy_to) begin
        r_abort    <= 1'b1;
        r_err_code <= C_ERR_DRDY;
      end

      if (w_lock_to) begin
        r_err_code <= C_ERR_LOCK;
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign busy      = (r_state != ST_IDLE);
  assign locked_o  = r_lock_s & (r_state == ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign pll_rst   = r_pll_rst;
  assign drp_den   = r_den;
  assign drp_dwe   = r_dwe;
  assign drp_daddr = r_addr;
  assign drp_di    = r_di;

endmodule
`default_nettype wire

// File: tb/tb_pll_drp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_drp_sequencer
// Brief    : Directed bench for pll_drp_sequencer with DRP slave, PLL lock
//            model and a transaction-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_drp_sequencer;

  localparam int RST_CYCLES   = 8;
  localparam int DRDY_TIMEOUT = 64;
  localparam int LOCK_TIMEOUT = 65535;
  localparam int LOCK_DELAY   = 20;
  localparam int DRDY_LAT     = 3;

  logic        refclk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [15:0] cmd_mask;
  logic        cmd_last;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic        locked_o;
  logic        pll_rst;
  logic        pll_locked;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;

  pll_drp_sequencer #(
    .RST_CYCLES  (RST_CYCLES),
    .DRDY_TIMEOUT(DRDY_TIMEOUT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_mask  (cmd_mask),
    .cmd_last  (cmd_last),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .locked_o  (locked_o),
    .pll_rst   (pll_rst),
    .pll_locked(pll_locked),
    .drp_den   (drp_den),
    .drp_dwe   (drp_dwe),
    .drp_daddr (drp_daddr),
    .drp_di    (drp_di),
    .drp_do    (drp_do),
    .drp_drdy  (drp_drdy)
  );

  always #5 refclk = ~refclk;

  int checks;
  int failures;

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
  } drp_op_t;

  drp_op_t     exp_q[$];
  logic [15:0] wr_log[$];
  drp_op_t     mon_op;
  logic [15:0] pll_regs [0:127];
  logic [15:0] ref_regs [0:127];
  int          n_rd, n_wr, n_done, n_err;
  bit          drdy_mute, lock_hold, lock_drop;
  int          slv_pend, lock_cnt;
  logic [6:0]  slv_addr;
  logic        slv_we;
  logic        prev_den, prev_dwe;
  logic        lock_p1, exp_lock_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired before the required event", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // DRP slave: answers each access DRDY_LAT cycles later, unless muted.
  initial begin
    drp_drdy = 1'b0;
    drp_do   = '0;
    slv_pend = 0;
    slv_addr = '0;
    slv_we   = 1'b0;
    forever begin
      @(negedge refclk);
      drp_drdy = 1'b0;
      if (slv_pend > 0) begin
        slv_pend--;
        if (slv_pend == 0) begin
          drp_drdy = 1'b1;
          if (!slv_we) drp_do = pll_regs[slv_addr];
        end
      end
      if (drp_den && !drdy_mute) begin
        slv_addr = drp_daddr;
        slv_we   = drp_dwe;
        slv_pend = DRDY_LAT;
        if (drp_dwe) pll_regs[drp_daddr] = drp_di;
      end
      if (!rst_n) slv_pend = 0;
    end
  end

  // PLL lock model: LOCKED rises LOCK_DELAY cycles after RST falls.
  initial begin
    pll_locked = 1'b0;
    lock_cnt   = 0;
    forever begin
      @(negedge refclk);
      if (pll_rst || lock_hold) begin
        lock_cnt   = 0;
        pll_locked = 1'b0;
      end else if (lock_cnt < LOCK_DELAY) begin
        lock_cnt++;
        pll_locked = (lock_cnt == LOCK_DELAY) && !lock_drop;
      end else begin
        pll_locked = !lock_drop;
      end
    end
  end

  // Expected synchronised lock: LOCKED as seen two rising edges earlier.
  initial begin
    lock_p1    = 1'b0;
    exp_lock_s = 1'b0;
    forever begin
      @(posedge refclk or negedge rst_n);
      if (!rst_n) begin
        lock_p1    = 1'b0;
        exp_lock_s = 1'b0;
      end else begin
        exp_lock_s = lock_p1;
        lock_p1    = pll_locked;
      end
    end
  end

  // Per-cycle compare against the model and the output rules.
  initial begin
    prev_den = 1'b0;
    prev_dwe = 1'b0;
    forever begin
      @(negedge refclk);
      check("den_one_cycle", 32'(drp_den & prev_den), 32'd0);
      check("dwe_one_cycle", 32'(drp_dwe & prev_dwe), 32'd0);
      check("dwe_needs_den", 32'(drp_dwe & ~drp_den), 32'd0);
      check("pll_rst_during_drp", 32'(drp_den & ~pll_rst), 32'd0);
      check("done_err_exclusive", 32'(done & err), 32'd0);
      if (!busy) begin
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("locked_o_idle", 32'(locked_o), 32'(exp_lock_s));
      end else begin
        check("locked_o_busy", 32'(locked_o), 32'd0);
      end
      if (drp_den) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL drp_unexpected: got access addr 0x%0h we %0b, required none",
                   drp_daddr, drp_dwe);
        end else begin
          mon_op = exp_q.pop_front();
          check("drp_we", 32'(drp_dwe), 32'(mon_op.we));
          check("drp_addr", 32'(drp_daddr), 32'(mon_op.addr));
          if (mon_op.we) begin
            check("drp_wdata", 32'(drp_di), 32'(mon_op.data));
            wr_log.push_back(drp_di);
            n_wr++;
          end else begin
            n_rd++;
          end
        end
      end
      if (done) n_done++;
      if (err)  n_err++;
      prev_den = drp_den;
      prev_dwe = drp_dwe;
    end
  end

  task automatic clear_counts();
    n_rd   = 0;
    n_wr   = 0;
    n_done = 0;
    n_err  = 0;
    wr_log.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_rst"},   32'(pll_rst),   32'd1);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd1);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
    check({tag, "_den"},       32'(drp_den),   32'd0);
    check({tag, "_dwe"},       32'(drp_dwe),   32'd0);
    check({tag, "_locked_o"},  32'(locked_o),  32'd0);
    check({tag, "_daddr"},     32'(drp_daddr), 32'd0);
    check({tag, "_di"},        32'(drp_di),    32'd0);
    check({tag, "_err_code"},  32'(err_code),  32'd0);
  endtask

  // Called on a falling edge right after rst_n is released.
  task automatic por_check(input string tag);
    int  n;
    int  k;
    bit  ok;
    clear_counts();
    n = 0;
    do begin
      @(negedge refclk);
      n++;
    end while (pll_rst && n < 100);
    check({tag, "_rst_len"}, 32'(n), 32'(RST_CYCLES));
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge refclk);
      if (pll_locked) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail({tag, "_pll_lock"});
    k  = 0;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge refclk);
      #1;
      k++;
      if (locked_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail({tag, "_locked_o_rise"});
    check({tag, "_locked_o_delay"}, 32'(k), 32'd2);
    tick(3);
    check({tag, "_no_done"}, 32'(n_done), 32'd0);
    check({tag, "_no_err"},  32'(n_err),  32'd0);
    check({tag, "_idle"},    32'(busy),   32'd0);
  endtask

  // Called on a falling edge; returns on the falling edge of the first read cycle.
  task automatic send_cmd(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m,
                          input logic l, input bit expect_wr);
    drp_op_t     op;
    logic [15:0] nv;
    bit          ok;
    op.we   = 1'b0;
    op.addr = a;
    op.data = '0;
    exp_q.push_back(op);
    if (expect_wr) begin
      nv          = (ref_regs[a] & m) | (d & ~m);
      ref_regs[a] = nv;
      op.we       = 1'b1;
      op.data     = nv;
      exp_q.push_back(op);
    end
    cmd_addr  = a;
    cmd_data  = d;
    cmd_mask  = m;
    cmd_last  = l;
    cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge refclk);
    end
    if (!ok) timeout_fail("cmd_accept");
    @(posedge refclk);
    @(negedge refclk);
    cmd_valid = 1'b0;
    check("den_after_accept", 32'(drp_den), 32'd1);
    check("rd_addr_after_accept", 32'(drp_daddr), 32'(a));
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge refclk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  ok;
    checks    = 0;
    failures  = 0;
    drdy_mute = 0;
    lock_hold = 0;
    lock_drop = 0;
    clear_counts();
    for (int i = 0; i < 128; i++) begin
      pll_regs[i] = 16'hA5A5;
      ref_regs[i] = 16'hA5A5;
    end
    pll_regs[9] = 16'h5A5A;
    ref_regs[9] = 16'h5A5A;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_mask  = '0;
    cmd_last  = 1'b0;

    // Reset state and power-on sequence
    tick(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    por_check("por");

    // Single command, masked read-modify-write
    clear_counts();
    send_cmd(7'h08, 16'h1041, 16'hF000, 1'b1, 1'b1);
    check("single_rd_we", 32'(drp_dwe), 32'd0);
    wait_idle("single_done", 300);
    tick(2);
    check("single_reads", 32'(n_rd), 32'd1);
    check("single_writes", 32'(n_wr), 32'd1);
    check("single_wdata", 32'(wr_log.size() > 0 ? wr_log[0] : 16'h0), 32'h0000A041);
    check("single_done_cnt", 32'(n_done), 32'd1);
    check("single_err_cnt", 32'(n_err), 32'd0);
    check("single_locked_o", 32'(locked_o), 32'd1);

    // Two-command group with an idle gap in ACCEPT
    clear_counts();
    send_cmd(7'h09, 16'h1234, 16'h00FF, 1'b0, 1'b1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge refclk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail("group_accept_state");
    for (int i = 0; i < 10; i++) begin
      check("gap_pll_rst", 32'(pll_rst), 32'd1);
      check("gap_cmd_ready", 32'(cmd_ready), 32'd1);
      check("gap_busy", 32'(busy), 32'd1);
      @(negedge refclk);
    end
    send_cmd(7'h0A, 16'hBEEF, 16'h0000, 1'b1, 1'b1);
    wait_idle("group_done", 300);
    tick(2);
    check("group_reads", 32'(n_rd), 32'd2);
    check("group_writes", 32'(n_wr), 32'd2);
    check("group_wdata0", 32'(wr_log.size() > 0 ? wr_log[0] : 16'h0), 32'h0000125A);
    check("group_wdata1", 32'(wr_log.size() > 1 ? wr_log[1] : 16'h0), 32'h0000BEEF);
    check("group_done_cnt", 32'(n_done), 32'd1);

    // DRDY never returns on the read
    clear_counts();
    drdy_mute = 1;
    send_cmd(7'h0B, 16'h0001, 16'h0000, 1'b1, 1'b0);
    k  = 0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge refclk);
      k++;
      if (err) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail("drdy_err");
    check("drdy_err_delay", 32'(k), 32'(DRDY_TIMEOUT + 1));
    check("drdy_err_code", 32'(err_code), 32'd1);
    check("drdy_pll_rst", 32'(pll_rst), 32'd0);
    drdy_mute = 0;
    wait_idle("drdy_relock", 300);
    tick(2);
    check("drdy_done_cnt", 32'(n_done), 32'd0);
    check("drdy_err_cnt", 32'(n_err), 32'd1);
    check("drdy_err_code_held", 32'(err_code), 32'd1);
    check("drdy_queue_empty", 32'(exp_q.size()), 32'd0);

    // LOCKED held low after release
    clear_counts();
    lock_hold = 1;
    send_cmd(7'h0C, 16'h00F0, 16'hFF0F, 1'b1, 1'b1);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge refclk);
      if (!pll_rst) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail("lock_release");
    k  = 0;
    ok = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge refclk);
      k++;
      if (err) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail("lock_err");
    check("lock_err_delay", 32'(k), 32'(LOCK_TIMEOUT + 1));
    check("lock_err_code", 32'(err_code), 32'd2);
    check("lock_locked_o", 32'(locked_o), 32'd0);
    check("lock_idle", 32'(busy), 32'd0);
    tick(2);
    check("lock_done_cnt", 32'(n_done), 32'd0);
    check("lock_err_cnt", 32'(n_err), 32'd1);
    check("lock_wdata", 32'(wr_log.size() > 0 ? wr_log[0] : 16'h0), 32'h0000A5F5);
    lock_hold = 0;
    tick(30);
    check("relock_locked_o", 32'(locked_o), 32'd1);

    // Lock loss and recovery while idle
    lock_drop = 1;
    tick(4);
    check("loss_locked_o", 32'(locked_o), 32'd0);
    check("loss_busy", 32'(busy), 32'd0);
    lock_drop = 0;
    tick(4);
    check("regain_locked_o", 32'(locked_o), 32'd1);

    // Reset asserted during WAIT_WR
    clear_counts();
    send_cmd(7'h11, 16'h3C3C, 16'h0F0F, 1'b1, 1'b1);
    check("accept_clears_err_code", 32'(err_code), 32'd0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge refclk);
      if (drp_den && drp_dwe) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail("midrst_write");
    @(negedge refclk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick(3);
    rst_n = 1'b1;
    por_check("midrst_por");
    check("midrst_wdata", 32'(ref_regs[7'h11]), 32'h00003535);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_drp_sequencer.md
Name: pll_drp_sequencer

Overview:
- Sequences run-time reconfiguration of the 7-series PLL through its Dynamic Reconfiguration Port (DRP).
- Accepts a stream of masked register-write commands from a requester, typically the core's video-mode or clock-select logic.
- Holds the PLL in reset while it performs read-modify-write cycles, then releases the PLL and qualifies LOCKED.
- Also performs the power-on reset sequence of the PLL. It sits between the PLL primitive wrapper and the clock consumers.

Parameters:
- RST_CYCLES, 8: cycles pll_rst is held at power-on before release (minimum 1).
- DRDY_TIMEOUT, 64: cycles to wait for drp_drdy after a DRP access before aborting.
- LOCK_TIMEOUT, 65535: cycles to wait for synchronised lock after releasing pll_rst (16-bit counter).

Ports:
- refclk  in  1  block clock; free-running, not derived from the controlled PLL.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  7  DRP register address.
- cmd_data  in  16  new bit values.
- cmd_mask  in  16  1 = keep the bit read from the PLL, 0 = take the cmd_data bit.
- cmd_last  in  1  final command of a reconfiguration group.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: group finished and PLL locked.
- err  out  1  one-cycle pulse on abort.
- err_code  out  2  0 none, 1 DRDY timeout, 2 lock timeout; held until the next accepted command.
- locked_o  out  1  qualified lock for downstream logic.
- pll_rst  out  1  to the PLL RST pin.
- pll_locked  in  1  PLL LOCKED, asynchronous to refclk.
- drp_den  out  1  DRP enable.
- drp_dwe  out  1  DRP write enable.
- drp_daddr  out  7  DRP address.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data.
- drp_drdy  in  1  DRP ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = INIT; pll_rst = 1; cmd_ready, done, err, drp_den, drp_dwe, locked_o = 0.
  - drp_daddr, drp_di = 0; err_code = 0; counters = 0; lock synchroniser flops = 0.
- pll_locked passes through a 2-flop synchroniser; lock_s is the synchronised signal.
- locked_o = lock_s & (state == IDLE). It drops the cycle the state leaves IDLE.
- INIT: pll_rst = 1 for RST_CYCLES cycles, then pll_rst = 0 and go to WAIT_LOCK. The power-on flag is set, so no done pulse is generated; err still fires on timeout.
- IDLE: cmd_ready = 1. On handshake: latch addr, data, mask and last; pll_rst = 1; clear err_code; go to RD.
- RD: drp_den = 1, drp_dwe = 0, drp_daddr = addr for exactly one cycle; go to WAIT_RD.
  - The first command's den is asserted 1 cycle after the accept edge.
- WAIT_RD: on drp_drdy, compute new = (drp_do & mask) | (data & ~mask) and go to WR.
- WR: drp_den = 1, drp_dwe = 1, drp_di = new for one cycle; go to WAIT_WR.
- WAIT_WR: on drp_drdy, go to RELEASE if last, else to ACCEPT.
- ACCEPT: cmd_ready = 1 and pll_rst stays 1. Waits indefinitely; on handshake, latch and go to RD.
- RELEASE: pll_rst = 0 for one cycle; clear the lock counter; go to WAIT_LOCK.
- WAIT_LOCK: when lock_s = 1, pulse done (unless power-on) and go to IDLE. If the counter reaches LOCK_TIMEOUT, pulse err, set err_code = 2, go to IDLE.
- DRDY timeout:
  - A counter runs in WAIT_RD and WAIT_WR. At DRDY_TIMEOUT, pulse err, set err_code = 1, force pll_rst = 0, go to WAIT_LOCK.
  - The lock wait still runs, but no done pulse is generated after an abort.
  - If that lock wait also times out, err_code = 2 overwrites 1.
- drp_den and drp_dwe are never high for more than one consecutive cycle.
- drp_drdy arriving outside WAIT_RD or WAIT_WR is ignored.
- cmd_ready is 0 in every state other than IDLE and ACCEPT.
- Lock loss while in IDLE: locked_o follows lock_s with no state change.
- rst_n asserted mid-sequence: immediate return to the reset values, including pll_rst = 1, then the INIT sequence.

Test Plan:
- Power-on, RST_CYCLES = 8, lock model raises LOCKED 20 cycles after RST falls -> pll_rst high for 8 cycles after reset release; locked_o rises 2 cycles after LOCKED; no done pulse.
- Single command addr = 0x08, data = 0x1041, mask = 0xF000, last = 1, drp_do = 0xA5A5 -> one read of 0x08, then one write of drp_di = 0xA041; pll_rst high throughout; done pulse once locked.
- Two-command group with cmd_valid idle for 10 cycles between the commands -> pll_rst stays 1 through ACCEPT; exactly 2 reads and 2 writes; one done pulse.
- drp_drdy never returns on a read -> err pulse after 64 cycles; err_code = 1; pll_rst released; no done pulse.
- LOCKED held low -> err pulse, err_code = 2 after 65535 cycles in WAIT_LOCK; locked_o = 0.
- rst_n pulsed low during WAIT_WR -> outputs return to reset values immediately; the INIT sequence repeats.
